// File: rtl/uart_prog_loader.sv
// UART program loader: takes a 4-byte little-endian length header, then writes that many bytes
// into instruction memory from address 0, holding the core in reset while the load is in progress.
module uart_prog_loader #(
    parameter int unsigned BYTE_ADDR_WIDTH = 6,
    parameter int unsigned TIMEOUT_CYCLES  = 1000000
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       prog_req,
    input  logic                       rx_valid,
    input  logic [7:0]                 rx_data,
    output logic                       mem_we,
    output logic [BYTE_ADDR_WIDTH-1:0] mem_byte_addr,
    output logic [7:0]                 mem_byte_data,
    output logic                       cpu_rst,
    output logic                       busy,
    output logic                       err
);
    localparam logic [32:0] CAPACITY   = 33'(1) << BYTE_ADDR_WIDTH;
    localparam logic [31:0] TIMER_LAST = (TIMEOUT_CYCLES == 0) ? '0 : 32'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LEN,
        S_DATA
    } state_e;

    state_e                     state_q, state_d;
    logic [31:0]                len_q, len_d;
    logic [31:0]                cnt_q, cnt_d;
    logic [31:0]                timer_q, timer_d;
    logic [1:0]                 hdr_q, hdr_d;
    logic                       mem_we_q, mem_we_d;
    logic [BYTE_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [7:0]                 data_q, data_d;
    logic                       cpu_rst_q, cpu_rst_d;
    logic                       busy_q, busy_d;
    logic                       err_q, err_d;
    logic                       timeout;

    always_comb begin
        // Timer holds cycles elapsed since the last reload; firing on the last value makes the
        // state change land exactly TIMEOUT_CYCLES edges after the reloading edge.
        timeout   = (TIMEOUT_CYCLES != 0) && (state_q != S_IDLE) && (timer_q == TIMER_LAST);
        state_d   = state_q;
        len_d     = len_q;
        cnt_d     = cnt_q;
        timer_d   = timer_q + 32'd1;
        hdr_d     = hdr_q;
        mem_we_d  = 1'b0;
        addr_d    = addr_q;
        data_d    = data_q;
        err_d     = err_q;

        case (state_q)
            S_IDLE: begin
                if (prog_req) begin
                    state_d = S_LEN;
                    len_d   = '0;
                    cnt_d   = '0;
                    timer_d = '0;
                    hdr_d   = '0;
                    err_d   = 1'b0;
                end
            end
            S_LEN: begin
                if (timeout) begin
                    state_d = S_IDLE;
                    err_d   = 1'b1;
                end else if (rx_valid) begin
                    len_d[{hdr_q, 3'b000} +: 8] = rx_data;
                    timer_d = '0;
                    hdr_d   = hdr_q + 2'd1;
                    if (hdr_q == 2'd3) begin
                        cnt_d   = '0;
                        state_d = ({rx_data, len_q[23:0]} == '0) ? S_IDLE : S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (timeout) begin
                    state_d = S_IDLE;
                    err_d   = 1'b1;
                end else if (rx_valid) begin
                    timer_d = '0;
                    cnt_d   = cnt_q + 32'd1;
                    if ({1'b0, cnt_q} < CAPACITY) begin
                        mem_we_d = 1'b1;
                        addr_d   = cnt_q[BYTE_ADDR_WIDTH-1:0];
                        data_d   = rx_data;
                    end
                    if (cnt_q + 32'd1 == len_q) begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        busy_d    = (state_d != S_IDLE);
        cpu_rst_d = busy_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            len_q     <= '0;
            cnt_q     <= '0;
            timer_q   <= '0;
            hdr_q     <= '0;
            mem_we_q  <= 1'b0;
            addr_q    <= '0;
            data_q    <= '0;
            cpu_rst_q <= 1'b1;
            busy_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            cnt_q     <= cnt_d;
            timer_q   <= timer_d;
            hdr_q     <= hdr_d;
            mem_we_q  <= mem_we_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            cpu_rst_q <= cpu_rst_d;
            busy_q    <= busy_d;
            err_q     <= err_d;
        end
    end

    assign mem_we        = mem_we_q;
    assign mem_byte_addr = addr_q;
    assign mem_byte_data = data_q;
    assign cpu_rst       = cpu_rst_q;
    assign busy          = busy_q;
    assign err           = err_q;
endmodule

// File: tb/tb_uart_prog_loader.sv
// Bench for uart_prog_loader: directed loads plus randomized loads checked against a
// transaction-level expectation of which bytes land at which address.
module tb_uart_prog_loader;
    localparam int unsigned AW  = 6;
    localparam int unsigned TMO = 100;
    localparam int unsigned CAP = 1 << AW;

    logic          clk = 1'b0;
    logic          rst;
    logic          prog_req;
    logic          rx_valid;
    logic [7:0]    rx_data;
    logic          mem_we;
    logic [AW-1:0] mem_byte_addr;
    logic [7:0]    mem_byte_data;
    logic          cpu_rst;
    logic          busy;
    logic          err;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;
    int unsigned wr_seen  = 0;
    int unsigned wr_exp   = 0;

    always #5 clk = ~clk;

    uart_prog_loader #(
        .BYTE_ADDR_WIDTH(AW),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .prog_req     (prog_req),
        .rx_valid     (rx_valid),
        .rx_data      (rx_data),
        .mem_we       (mem_we),
        .mem_byte_addr(mem_byte_addr),
        .mem_byte_data(mem_byte_data),
        .cpu_rst      (cpu_rst),
        .busy         (busy),
        .err          (err)
    );

    always @(negedge clk) if (mem_we === 1'b1) wr_seen++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int unsigned cycles);
        for (int unsigned i = 0; i < cycles; i++) begin
            tick();
            check("idle_we", mem_we, 0);
        end
    endtask

    task automatic send(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        tick();
        rx_valid = 1'b0;
        rx_data  = 8'($urandom);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_we"}, mem_we, 0);
        check({tag, "_addr"}, 32'(mem_byte_addr), 0);
        check({tag, "_data"}, 32'(mem_byte_data), 0);
        check({tag, "_cpu_rst"}, cpu_rst, 1);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_err"}, err, 0);
    endtask

    task automatic start_load();
        prog_req = 1'b1;
        tick();
        prog_req = 1'b0;
        check("start_busy", busy, 1);
        check("start_cpu_rst", cpu_rst, 1);
        check("start_err", err, 0);
    endtask

    task automatic send_header(input logic [31:0] n);
        for (int unsigned k = 0; k < 4; k++) begin
            idle($urandom_range(0, 3));
            send(n[8*k +: 8]);
            check("hdr_we", mem_we, 0);
            if (k < 3) check("hdr_busy", busy, 1);
        end
    endtask

    // Expected: byte i is written to address i one cycle after it arrives while i < CAP;
    // the load ends (busy/cpu_rst low) on the edge that accepts byte n-1.
    task automatic run_load(input int unsigned n, input logic [7:0] q[$]);
        start_load();
        send_header(n);
        if (n == 0) begin
            check("hdr0_busy", busy, 0);
            check("hdr0_cpu_rst", cpu_rst, 0);
            return;
        end
        check("hdr_done_busy", busy, 1);
        for (int unsigned i = 0; i < q.size(); i++) begin
            idle($urandom_range(0, 2));
            send(q[i]);
            if (i < CAP) begin
                wr_exp++;
                check("data_we", mem_we, 1);
                check("data_addr", 32'(mem_byte_addr), i);
                check("data_byte", 32'(mem_byte_data), 32'(q[i]));
            end else begin
                check("drop_we", mem_we, 0);
            end
            check("data_busy", busy, (i + 1 == n) ? 0 : 1);
            check("data_cpu_rst", cpu_rst, (i + 1 == n) ? 0 : 1);
        end
    endtask

    initial begin
        logic [7:0] q[$];
        int unsigned n;
        rst      = 1'b1;
        prog_req = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        repeat (3) tick();
        check_reset_values("reset");
        rst = 1'b0;
        tick();
        check("release_cpu_rst", cpu_rst, 0);
        check("release_busy", busy, 0);

        q = {};
        q.push_back(8'hDE); q.push_back(8'hAD); q.push_back(8'hBE); q.push_back(8'hEF);
        run_load(4, q);
        check("t1_err", err, 0);
        idle(2);

        q = {};
        run_load(0, q);
        idle(2);

        q = {};
        for (int unsigned i = 0; i < 66; i++) q.push_back(8'(i));
        run_load(66, q);
        idle(3);

        // Timeout in DATA after three bytes of an 8-byte image.
        q = {};
        for (int unsigned i = 0; i < 3; i++) q.push_back(8'($urandom));
        run_load(8, q);
        idle(TMO - 1);
        check("tmo_busy_before", busy, 1);
        check("tmo_err_before", err, 0);
        tick();
        check("tmo_err", err, 1);
        check("tmo_busy", busy, 0);
        check("tmo_cpu_rst", cpu_rst, 0);
        idle(2);
        check("tmo_err_sticky", err, 1);
        start_load();
        send_header(0);
        check("tmo_hdr0_busy", busy, 0);

        // A byte arriving on the timeout cycle is dropped.
        q = {};
        q.push_back(8'h11);
        run_load(8, q);
        idle(TMO - 1);
        check("race_busy_before", busy, 1);
        send(8'h77);
        check("race_we", mem_we, 0);
        check("race_err", err, 1);
        check("race_busy", busy, 0);
        idle(2);

        // Reset mid-load.
        q = {};
        q.push_back(8'hA5); q.push_back(8'h5A);
        run_load(8, q);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_reset_values("midrst");
        tick();
        check("midrst_cpu_rst", cpu_rst, 0);
        for (int unsigned i = 0; i < 4; i++) begin
            send(8'($urandom));
            check("midrst_we", mem_we, 0);
        end

        // Traffic in IDLE belongs to running software.
        for (int unsigned i = 0; i < 12; i++) begin
            idle($urandom_range(0, 2));
            send(8'($urandom));
            check("idle_rx_we", mem_we, 0);
            check("idle_rx_cpu_rst", cpu_rst, 0);
        end

        // prog_req held high: LEN re-entered the cycle after IDLE is reached.
        prog_req = 1'b1;
        tick();
        check("hold_busy", busy, 1);
        send_header(1);
        send(8'h3C);
        wr_exp++;
        check("hold_we", mem_we, 1);
        check("hold_addr", 32'(mem_byte_addr), 0);
        check("hold_data", 32'(mem_byte_data), 32'h3C);
        check("hold_idle", busy, 0);
        tick();
        check("hold_reenter_busy", busy, 1);
        check("hold_reenter_cpu_rst", cpu_rst, 1);
        prog_req = 1'b0;
        send_header(0);
        check("hold_exit_busy", busy, 0);

        repeat (6) begin
            n = $urandom_range(1, 70);
            q = {};
            for (int unsigned i = 0; i < n; i++) q.push_back(8'($urandom));
            run_load(n, q);
            check("rand_err", err, 0);
            idle($urandom_range(1, 3));
        end

        idle(2);
        check("write_count", wr_seen, wr_exp);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
